fetch_stage: RTL and testbench

- Instruction-fetch stage plus F/D pipeline register of the 5-stage MIPS core; sits directly upstream of the decode stage.
- Holds the PC, addresses the combinational instruction memory, and applies decode-stage branch/jump redirects under delay-slot semantics.
- Applies hazard-unit stall/flush and delivers D_ins/D_PC to decode, with fetch/stall performance counters.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_fd_reg.sv | 60 ++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its F/D pipeline register.
//
// Contents:
//   NOP              - instruction word inserted for bubbles and faulted fetches
//   RESET_PC_DEFAULT - default reset PC and instruction-memory base address
//   CNT_W            - width of the performance counters
//
// Optional feature macro used by the files importing this package:
//   FETCH_ADEL_EN    - adds the D_adel fetch-address-error flag
package fetch_stage_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam int          CNT_W            = 32;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: the instruction word, its PC and a valid bit
// handed to the decode stage.
//
// Update priority on each rising edge, highest first:
//   reset == 0 : bubble (NOP, PC 0, invalid)
//   flush      : bubble, even while stalled
//   stall      : hold
//   otherwise  : load load_ins / load_pc, mark valid
//
// Ports:
//   clk, reset (sync, active-low), stall, flush
//   load_ins, load_pc : word and PC captured on a normal load
//   load_adel         : address-error flag captured on a normal load (FETCH_ADEL_EN)
//   D_ins, D_PC, D_valid, D_adel (FETCH_ADEL_EN) : register outputs
//
// Optional feature macro: FETCH_ADEL_EN
module fetch_stage_fd_reg
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] load_ins,
   input  logic [31:0] load_pc,
`ifdef FETCH_ADEL_EN
   input  logic        load_adel,
`endif
   output logic [31:0] D_ins,
   output logic [31:0] D_PC,
   output logic        D_valid
`ifdef FETCH_ADEL_EN
   ,
   output logic        D_adel
`endif
);

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         D_ins   <= NOP;
         D_PC    <= 32'h0;
         D_valid <= 1'b0;
      end else if (!stall) begin
         D_ins   <= load_ins;
         D_PC    <= load_pc;
         D_valid <= 1'b1;
      end
   end

`ifdef FETCH_ADEL_EN
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         D_adel <= 1'b0;
      end else if (!stall) begin
         D_adel <= load_adel;
      end
   end
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS core, including the F/D
// pipeline register feeding decode.
//
// The PC addresses a combinational instruction memory. A decode-stage
// redirect (br_taken/br_target) has delay-slot semantics: the word fetched in
// the redirect cycle still enters F/D, and the target is fetched next cycle.
// stall freezes the PC and F/D; flush turns F/D into a bubble (the PC still
// obeys stall). fetch_cnt counts normal F/D loads, stall_cnt stalled cycles.
//
// Ports:
//   clk, reset (sync, active-low)
//   stall, flush            : hazard-unit controls
//   br_taken, br_target     : decode-stage redirect
//   im_addr, im_rdata       : instruction-memory word address / data (same cycle)
//   F_PC                    : current fetch PC
//   D_ins, D_PC, D_valid    : F/D register outputs to decode
//   D_adel                  : fetch address error (FETCH_ADEL_EN only)
//   fetch_cnt, stall_cnt    : wrapping performance counters
//
// Optional feature macro: FETCH_ADEL_EN
//   When defined, a misaligned or out-of-memory PC loads a NOP into F/D with
//   D_adel set. When undefined, such PCs fetch from the wrapped word address.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          IM_ADDR_W = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 br_taken,
   input  logic [31:0]          br_target,
   output logic [IM_ADDR_W-1:0] im_addr,
   input  logic [31:0]          im_rdata,
   output logic [31:0]          F_PC,
   output logic [31:0]          D_ins,
   output logic [31:0]          D_PC,
   output logic                 D_valid,
`ifdef FETCH_ADEL_EN
   output logic                 D_adel,
`endif
   output logic [CNT_W-1:0]     fetch_cnt,
   output logic [CNT_W-1:0]     stall_cnt
);

   logic [31:0] pc_q;
   logic [31:0] pc_off;
   logic [31:0] next_pc;
   logic        load_en;
   logic [31:0] load_ins;

   // Offset from the memory base; its word bits form the memory address and
   // anything beyond the memory simply wraps.
   assign pc_off  = pc_q - RESET_PC;
   assign im_addr = pc_off[IM_ADDR_W+1:2];
   assign F_PC    = pc_q;

   assign next_pc = br_taken ? br_target : pc_q + 32'd4;

   // A redirect seen during a stall is dropped; decode re-presents it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else if (!stall) begin
         pc_q <= next_pc;
      end
   end

   assign load_en = !flush && !stall;

`ifdef FETCH_ADEL_EN
   logic pc_faulty;

   // Below-base PCs give a huge unsigned offset, so one upper-bits test
   // covers both ends of the memory window.
   assign pc_faulty = (pc_q[1:0] != 2'b00) || (pc_off[31:IM_ADDR_W+2] != '0);
   assign load_ins  = pc_faulty ? NOP : im_rdata;
`else
   logic unused_pc_off;

   assign unused_pc_off = ^pc_off[31:IM_ADDR_W+2];
   assign load_ins      = im_rdata;
`endif

   logic unused_pc_low;
   assign unused_pc_low = ^pc_off[1:0];

   fetch_stage_fd_reg u_fd_reg (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .flush    (flush),
      .load_ins (load_ins),
      .load_pc  (pc_q),
`ifdef FETCH_ADEL_EN
      .load_adel(pc_faulty),
`endif
      .D_ins    (D_ins),
      .D_PC     (D_PC),
      .D_valid  (D_valid)
`ifdef FETCH_ADEL_EN
      ,
      .D_adel   (D_adel)
`endif
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (load_en) begin
            fetch_cnt <= fetch_cnt + 1'b1;
         end
         if (stall) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the stage.
module tb_fetch_stage;

   localparam logic [31:0] RPC   = 32'h0000_3000;
   localparam int          AW    = 12;
   localparam int          DEPTH = 1 << AW;
`ifdef FETCH_ADEL_EN
   localparam bit ADEL = 1'b1;
`else
   localparam bit ADEL = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          br_taken = 1'b0;
   logic [31:0]   br_target = 32'h0;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_rdata;
   logic [31:0]   F_PC, D_ins, D_PC;
   logic          D_valid;
   logic          D_adel;
   logic [31:0]   fetch_cnt, stall_cnt;

   // instruction memory
   logic [31:0] im_mem [DEPTH];
   assign im_rdata = im_mem[im_addr];

`ifndef FETCH_ADEL_EN
   assign D_adel = 1'b0;
`endif

   fetch_stage #(.RESET_PC(RPC), .IM_ADDR_W(AW)) dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .flush    (flush),
      .br_taken (br_taken),
      .br_target(br_target),
      .im_addr  (im_addr),
      .im_rdata (im_rdata),
      .F_PC     (F_PC),
      .D_ins    (D_ins),
      .D_PC     (D_PC),
      .D_valid  (D_valid),
`ifdef FETCH_ADEL_EN
      .D_adel   (D_adel),
`endif
      .fetch_cnt(fetch_cnt),
      .stall_cnt(stall_cnt)
   );

   int errors = 0;
   int checks = 0;

   // behavioural model state
   logic [31:0] m_pc = RPC;
   logic [31:0] m_ins = 32'h0;
   logic [31:0] m_dpc = 32'h0;
   logic        m_valid = 1'b0;
   logic        m_adel = 1'b0;
   logic [31:0] m_fcnt = 32'h0;
   logic [31:0] m_scnt = 32'h0;

   function automatic logic [AW-1:0] word_index(input logic [31:0] pc);
      logic [31:0] off;
      off = pc - RPC;
      return off[AW+1:2];
   endfunction

   function automatic bit pc_bad(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < RPC) || (pc >= RPC + 32'(4 * DEPTH));
   endfunction

   // Update the model from the inputs present before the edge, then advance
   // past the edge so outputs are sampled 1 time unit later.
   task automatic tick();
      logic [31:0] pc_now;
      pc_now = m_pc;
      if (!reset) begin
         m_pc = RPC; m_ins = 32'h0; m_dpc = 32'h0; m_valid = 1'b0;
         m_adel = 1'b0; m_fcnt = 32'h0; m_scnt = 32'h0;
      end else begin
         if (flush) begin
            m_ins = 32'h0; m_dpc = 32'h0; m_valid = 1'b0; m_adel = 1'b0;
         end else if (!stall) begin
            m_dpc   = pc_now;
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 32'd1;
            if (ADEL && pc_bad(pc_now)) begin
               m_ins = 32'h0; m_adel = 1'b1;
            end else begin
               m_ins = im_mem[word_index(pc_now)]; m_adel = 1'b0;
            end
         end
         if (stall) m_scnt = m_scnt + 32'd1;
         else       m_pc = br_taken ? br_target : pc_now + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b1; flush = 1'b0; br_taken = 1'b1; br_target = 32'h5000;
      tick();
      tick();
      checks++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL reset_f_pc: got %h expected %h", F_PC, 32'h3000); end
      checks++; if (D_ins !== 32'h0) begin errors++; $display("FAIL reset_d_ins: got %h expected %h", D_ins, 32'h0); end
      checks++; if (D_PC !== 32'h0) begin errors++; $display("FAIL reset_d_pc: got %h expected %h", D_PC, 32'h0); end
      checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b expected 0", D_valid); end
      checks++; if (D_adel !== 1'b0) begin errors++; $display("FAIL reset_d_adel: got %b expected 0", D_adel); end
      checks++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
         errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", fetch_cnt, stall_cnt);
      end
      checks++; if (im_addr !== 12'h000) begin errors++; $display("FAIL reset_im_addr: got %h expected 000", im_addr); end
      stall = 1'b0; br_taken = 1'b0;
   endtask

   task automatic test_first_fetch();
      im_mem[0] = 32'h3C01_1234;
      reset = 1'b1;
      tick();
      checks++; if (F_PC !== 32'h3004) begin errors++; $display("FAIL first_f_pc: got %h expected %h", F_PC, 32'h3004); end
      checks++; if (D_ins !== 32'h3C01_1234) begin errors++; $display("FAIL first_d_ins: got %h expected %h", D_ins, 32'h3C01_1234); end
      checks++; if (D_PC !== 32'h3000) begin errors++; $display("FAIL first_d_pc: got %h expected %h", D_PC, 32'h3000); end
      checks++; if (D_valid !== 1'b1) begin errors++; $display("FAIL first_d_valid: got %b expected 1", D_valid); end
      checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL first_fetch_cnt: got %0d expected 1", fetch_cnt); end
      checks++; if (im_addr !== 12'h001) begin errors++; $display("FAIL first_im_addr: got %h expected 001", im_addr); end
   endtask

   task automatic test_branch();
      tick();
      checks++; if (F_PC !== 32'h3008) begin errors++; $display("FAIL br_pre_f_pc: got %h expected %h", F_PC, 32'h3008); end
      br_taken = 1'b1; br_target = 32'h3040;
      tick();
      br_taken = 1'b0;
      checks++; if (D_PC !== 32'h3008) begin errors++; $display("FAIL br_delay_slot_pc: got %h expected %h", D_PC, 32'h3008); end
      checks++; if (D_ins !== m_ins) begin errors++; $display("FAIL br_delay_slot_ins: got %h expected %h", D_ins, m_ins); end
      checks++; if (F_PC !== 32'h3040) begin errors++; $display("FAIL br_target_f_pc: got %h expected %h", F_PC, 32'h3040); end
      tick();
      checks++; if (D_PC !== 32'h3040) begin errors++; $display("FAIL br_target_d_pc: got %h expected %h", D_PC, 32'h3040); end
      checks++; if (D_ins !== im_mem[16]) begin errors++; $display("FAIL br_target_d_ins: got %h expected %h", D_ins, im_mem[16]); end
      checks++; if (F_PC !== 32'h3044) begin errors++; $display("FAIL br_after_f_pc: got %h expected %h", F_PC, 32'h3044); end
   endtask

   task automatic test_stall();
      logic [31:0] held_ins;
      held_ins = m_ins;
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (F_PC !== 32'h3044) begin errors++; $display("FAIL stall_f_pc: got %h expected %h", F_PC, 32'h3044); end
      checks++; if (D_PC !== 32'h3040) begin errors++; $display("FAIL stall_d_pc: got %h expected %h", D_PC, 32'h3040); end
      checks++; if (D_ins !== held_ins) begin errors++; $display("FAIL stall_d_ins: got %h expected %h", D_ins, held_ins); end
      checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
      checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL stall_fetch_cnt: got %0d expected 4", fetch_cnt); end
      stall = 1'b0; br_taken = 1'b0;
      tick();
      checks++; if (F_PC !== 32'h3048) begin errors++; $display("FAIL stall_release_f_pc: got %h expected %h", F_PC, 32'h3048); end
      checks++; if (D_PC !== 32'h3044) begin errors++; $display("FAIL stall_release_d_pc: got %h expected %h", D_PC, 32'h3044); end
   endtask

   task automatic test_flush_stall();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (F_PC !== 32'h3010) begin errors++; $display("FAIL flush_pre_f_pc: got %h expected %h", F_PC, 32'h3010); end
      flush = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 32'h3200;
      tick();
      flush = 1'b0; stall = 1'b0; br_taken = 1'b0;
      checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL flush_d_valid: got %b expected 0", D_valid); end
      checks++; if (D_ins !== 32'h0 || D_PC !== 32'h0) begin
         errors++; $display("FAIL flush_bubble: got %h/%h expected 0/0", D_ins, D_PC);
      end
      checks++; if (F_PC !== 32'h3010) begin errors++; $display("FAIL flush_f_pc_hold: got %h expected %h", F_PC, 32'h3010); end
      checks++; if (fetch_cnt !== 32'd4 || stall_cnt !== 32'd1) begin
         errors++; $display("FAIL flush_counters: got %0d/%0d expected 4/1", fetch_cnt, stall_cnt);
      end
      tick();
      checks++; if (D_PC !== 32'h3010 || D_valid !== 1'b1) begin
         errors++; $display("FAIL flush_resume: got %h/%b expected %h/1", D_PC, D_valid, 32'h3010);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_ins;
      br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
      tick();
      br_taken = 1'b0;
      checks++; if (F_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_f_pc: got %h expected %h", F_PC, 32'hFFFF_FFFC); end
      checks++; if (im_addr !== 12'h3FF) begin errors++; $display("FAIL wrap_top_im_addr: got %h expected 3ff", im_addr); end
      tick();
      checks++; if (F_PC !== 32'h0) begin errors++; $display("FAIL wrap_zero_f_pc: got %h expected 0", F_PC); end
      checks++; if (im_addr !== 12'h400) begin errors++; $display("FAIL wrap_zero_im_addr: got %h expected 400", im_addr); end
      exp_ins = ADEL ? 32'h0 : im_mem[12'h3FF];
      checks++; if (D_PC !== 32'hFFFF_FFFC || D_ins !== exp_ins) begin
         errors++; $display("FAIL wrap_top_load: got %h/%h expected %h/%h", D_PC, D_ins, 32'hFFFF_FFFC, exp_ins);
      end
      checks++; if (D_adel !== ADEL) begin errors++; $display("FAIL wrap_top_adel: got %b expected %b", D_adel, ADEL); end
      tick();
      exp_ins = ADEL ? 32'h0 : im_mem[12'h400];
      checks++; if (D_PC !== 32'h0 || D_ins !== exp_ins || D_valid !== 1'b1) begin
         errors++; $display("FAIL wrap_zero_load: got %h/%h/%b expected 0/%h/1", D_PC, D_ins, D_valid, exp_ins);
      end
      checks++; if (D_adel !== ADEL) begin errors++; $display("FAIL wrap_zero_adel: got %b expected %b", D_adel, ADEL); end
   endtask

   task automatic test_reset_mid_stall();
      checks++; if (D_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid: got %b expected 1", D_valid); end
      stall = 1'b1; br_taken = 1'b1; br_target = 32'h3300; reset = 1'b0;
      tick();
      checks++; if (F_PC !== 32'h3000 || D_valid !== 1'b0 || D_ins !== 32'h0 || D_PC !== 32'h0) begin
         errors++; $display("FAIL rst_mid_state: got %h/%b/%h/%h expected 3000/0/0/0", F_PC, D_valid, D_ins, D_PC);
      end
      checks++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0 || D_adel !== 1'b0) begin
         errors++; $display("FAIL rst_mid_counters: got %h/%h/%b expected 0/0/0", fetch_cnt, stall_cnt, D_adel);
      end
      reset = 1'b1; stall = 1'b0; br_taken = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 49) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 5) == 0);
         br_taken = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 4) == 0) br_target = $urandom();
         else br_target = RPC + ($urandom_range(0, DEPTH - 1) << 2);
         tick();
         checks++; if (F_PC !== m_pc) begin errors++; $display("FAIL rnd_f_pc[%0d]: got %h expected %h", n, F_PC, m_pc); end
         checks++; if (im_addr !== word_index(m_pc)) begin errors++; $display("FAIL rnd_im_addr[%0d]: got %h expected %h", n, im_addr, word_index(m_pc)); end
         checks++; if (D_ins !== m_ins) begin errors++; $display("FAIL rnd_d_ins[%0d]: got %h expected %h", n, D_ins, m_ins); end
         checks++; if (D_PC !== m_dpc) begin errors++; $display("FAIL rnd_d_pc[%0d]: got %h expected %h", n, D_PC, m_dpc); end
         checks++; if (D_valid !== m_valid) begin errors++; $display("FAIL rnd_d_valid[%0d]: got %b expected %b", n, D_valid, m_valid); end
         checks++; if (D_adel !== m_adel) begin errors++; $display("FAIL rnd_d_adel[%0d]: got %b expected %b", n, D_adel, m_adel); end
         checks++; if (fetch_cnt !== m_fcnt) begin errors++; $display("FAIL rnd_fetch_cnt[%0d]: got %0d expected %0d", n, fetch_cnt, m_fcnt); end
         checks++; if (stall_cnt !== m_scnt) begin errors++; $display("FAIL rnd_stall_cnt[%0d]: got %0d expected %0d", n, stall_cnt, m_scnt); end
      end
      reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) im_mem[i] = $urandom();
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_branch();
      test_stall();
      test_flush_stall();
      test_wrap();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
